id_operand_scoreboard: RTL

- Parametrised successor to the ID-stage operand read path.
- Resolves NUM_READ source operands per instruction: register-file data, write-back bypass, or priority forwarding from NUM_FWD downstream stages.
- A per-register latency scoreboard detects operands that are not yet forwardable and raises a hazard so IF/ID hold and a bubble is issued to EX.
- Outputs are registered and sit in the ID/EX interstage boundary.

---
 rtl/id_operand_scoreboard_if.sv | 43 ++++
 rtl/id_operand_scoreboard.sv | 130 +++++++++++++
 2 files changed

// File: rtl/id_operand_scoreboard_if.sv
// ID-stage operand read bus: instruction sources, forwarding/write-back
// inputs, and the registered ID/EX operand outputs plus the hazard flag.
interface id_operand_scoreboard_if #(
  parameter int REGADDR_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_READ      = 2,
  parameter int NUM_FWD       = 3,
  parameter int MAX_LAT       = 3
);
  localparam int LATW = $clog2(MAX_LAT + 1);

  logic                              stall;
  logic                              clear;
  logic                              in_valid;
  logic [NUM_READ*REGADDR_WIDTH-1:0] rd_addr;
  logic [NUM_READ*DATA_WIDTH-1:0]    rf_data;
  logic [REGADDR_WIDTH-1:0]          dst_addr;
  logic [LATW-1:0]                   dst_lat;
  logic [NUM_FWD-1:0]                fwd_valid;
  logic [NUM_FWD*REGADDR_WIDTH-1:0]  fwd_addr;
  logic [NUM_FWD*DATA_WIDTH-1:0]     fwd_data;
  logic [REGADDR_WIDTH-1:0]          wb_addr;
  logic [DATA_WIDTH-1:0]             wb_data;
  logic                              hazard;
  logic                              out_valid;
  logic [NUM_READ*REGADDR_WIDTH-1:0] out_addr;
  logic [NUM_READ*DATA_WIDTH-1:0]    out_data;
  logic [REGADDR_WIDTH-1:0]          out_dst;

  // Pipeline-control / decode side that drives the instruction.
  modport master (
    output stall, clear, in_valid, rd_addr, rf_data, dst_addr, dst_lat,
           fwd_valid, fwd_addr, fwd_data, wb_addr, wb_data,
    input  hazard, out_valid, out_addr, out_data, out_dst
  );

  // Operand scoreboard side.
  modport slave (
    input  stall, clear, in_valid, rd_addr, rf_data, dst_addr, dst_lat,
           fwd_valid, fwd_addr, fwd_data, wb_addr, wb_data,
    output hazard, out_valid, out_addr, out_data, out_dst
  );
endinterface

// File: rtl/id_operand_scoreboard.sv
// ID-stage operand resolver with a per-register latency scoreboard.
// Each source operand resolves from zero / forwarding / write-back / RF;
// operands whose producer has not reached a forwarding port raise hazard.
module id_operand_scoreboard #(
  parameter int REGADDR_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_READ      = 2,
  parameter int NUM_FWD       = 3,
  parameter int MAX_LAT       = 3
) (
  input logic                  clk,
  input logic                  rst,
  id_operand_scoreboard_if.slave bus
);
  localparam int LATW = $clog2(MAX_LAT + 1);
  localparam int NREG = 1 << REGADDR_WIDTH;
  localparam int RW   = REGADDR_WIDTH;
  localparam int DW   = DATA_WIDTH;

  logic [LATW-1:0]        cnt_q [NREG];
  logic [LATW-1:0]        cnt_d [NREG];
  logic [NUM_READ-1:0]    pend;
  logic [NUM_READ*DW-1:0] res_data;
  logic [LATW-1:0]        lat_sat;
  logic                   hazard;
  logic                   issue;

  logic                   out_valid_q;
  logic [NUM_READ*RW-1:0] out_addr_q;
  logic [NUM_READ*DW-1:0] out_data_q;
  logic [RW-1:0]          out_dst_q;

  genvar gi;

  // Per-port operand resolution and pending detection.
  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : gen_port
      logic [RW-1:0] a;
      logic          hit;
      logic [DW-1:0] val;

      assign a = bus.rd_addr[gi*RW +: RW];

      // Priority select: scan forwarding sources oldest-first so the
      // youngest (lowest index) match is the one left standing.
      always_comb begin
        hit = 1'b0;
        val = bus.rf_data[gi*DW +: DW];
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
          if (bus.fwd_valid[k] && (bus.fwd_addr[k*RW +: RW] == a)) begin
            hit = 1'b1;
            val = bus.fwd_data[k*DW +: DW];
          end
        end
        if (!hit && (bus.wb_addr == a)) begin
          val = bus.wb_data;
        end
        if (a == '0) begin
          val = '0;
        end
      end

      assign res_data[gi*DW +: DW] = val;
      assign pend[gi] = (a != '0) && (cnt_q[a] != '0) && !hit;
    end
  endgenerate

  assign hazard  = bus.in_valid & (|pend);
  assign issue   = bus.in_valid & ~hazard & ~bus.stall & ~bus.clear;
  assign lat_sat = (bus.dst_lat > LATW'(MAX_LAT)) ? LATW'(MAX_LAT) : bus.dst_lat;

  // Counter next state: a fresh issue to a register overrides its decrement.
  // Register 0 never tracks a producer.
  generate
    for (gi = 0; gi < NREG; gi++) begin : gen_cnt
      if (gi == 0) begin : g_zero
        assign cnt_d[gi] = '0;
      end else begin : g_reg
        assign cnt_d[gi] = bus.stall                             ? cnt_q[gi] :
                           bus.clear                             ? '0 :
                           (issue && (bus.dst_addr == RW'(gi)))  ? lat_sat :
                           (cnt_q[gi] != '0)                     ? cnt_q[gi] - LATW'(1) :
                                                                   '0;
      end
    end
  endgenerate

  // Scoreboard counter register file.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (rst) begin
        cnt_q[r] <= '0;
      end else begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // ID/EX boundary registers; a non-issuing cycle sends a bubble but keeps
  // the last operands so nothing toggles needlessly downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_dst_q   <= '0;
    end else if (bus.stall) begin
      out_valid_q <= out_valid_q;
    end else if (bus.clear) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_dst_q   <= '0;
    end else if (issue) begin
      out_valid_q <= 1'b1;
      out_addr_q  <= bus.rd_addr;
      out_data_q  <= res_data;
      out_dst_q   <= bus.dst_addr;
    end else begin
      out_valid_q <= 1'b0;
      out_dst_q   <= '0;
    end
  end

  assign bus.hazard    = hazard;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_dst   = out_dst_q;
endmodule
